// File: rtl/spi_slave.sv
// SPI slave with 2-FF input synchronizers, all four CPOL/CPHA modes, MSB-first,
// a one-word TX buffer and a one-word RX holding register with overrun/underrun flags.
module spi_slave #(
  parameter int unsigned        DATA_W  = 8,
  parameter bit                 CPOL    = 1'b0,
  parameter bit                 CPHA    = 1'b0,
  parameter logic [DATA_W-1:0]  TX_IDLE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_q;
  logic cs_s1, cs_s2, cs_q;
  logic mosi_s1, mosi_s2;
  logic sync_primed, cs_armed;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_buf;

  logic cs_fall, cs_rise, lead_edge, trail_edge;
  logic start, abort, sample, shift;
  logic word_done, load, tx_wr;
  logic [DATA_W-1:0] tx_word;

  // Synchronizers; cs_armed blocks a transfer from starting until CS has been
  // seen high after reset, so a CS held low through reset is not taken as a fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_s1     <= CPOL;
      sclk_s2     <= CPOL;
      sclk_q      <= CPOL;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_q        <= 1'b1;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      sync_primed <= 1'b0;
      cs_armed    <= 1'b0;
    end else begin
      sclk_s1     <= sclk_i;
      sclk_s2     <= sclk_s1;
      sclk_q      <= sclk_s2;
      cs_s1       <= cs_i;
      cs_s2       <= cs_s1;
      cs_q        <= cs_s2;
      mosi_s1     <= mosi_i;
      mosi_s2     <= mosi_s1;
      sync_primed <= 1'b1;
      if (sync_primed && cs_s1) begin
        cs_armed <= 1'b1;
      end
    end
  end

  assign cs_fall    = cs_armed && cs_q && !cs_s2;
  assign cs_rise    = !cs_q && cs_s2;
  assign lead_edge  = (sclk_s2 != CPOL) && (sclk_q == CPOL);
  assign trail_edge = (sclk_s2 == CPOL) && (sclk_q != CPOL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle strobes; CPHA=0 skips the shift edge that follows
  // the last sample so the freshly loaded MSB stays on the line.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    abort      = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (CPHA) begin
          sample = trail_edge;
          shift  = lead_edge;
        end else begin
          sample = lead_edge;
          shift  = trail_edge && (bit_cnt != '0);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign word_done = sample && (bit_cnt == LAST_BIT);
  assign load      = start || word_done;
  assign tx_wr     = tx_valid_i && tx_ready_o;
  assign tx_word   = tx_ready_o ? TX_IDLE : tx_buf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_buf        <= '0;
      tx_ready_o    <= 1'b1;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
      miso_o        <= 1'b0;
      miso_oe_o     <= 1'b0;
    end else begin
      miso_oe_o     <= !cs_s1;
      tx_underrun_o <= load && tx_ready_o;
      rx_overrun_o  <= 1'b0;

      if (tx_wr) begin
        tx_buf     <= tx_data_i;
        tx_ready_o <= 1'b0;
      end else if (load) begin
        tx_ready_o <= 1'b1;
      end

      if (start || abort) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sample) begin
        bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
        rx_shift <= {rx_shift[DATA_W-3:0], mosi_s2};
      end

      if (word_done) begin
        rx_data_o    <= {rx_shift, mosi_s2};
        rx_valid_o   <= 1'b1;
        rx_overrun_o <= rx_valid_o && !rx_ready_i;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      // MISO follows cs_s1 so it drops in the same cycle the enable does.
      if (cs_s1) begin
        miso_o <= 1'b0;
      end else if (load) begin
        if (CPHA) begin
          tx_shift <= tx_word;
        end else begin
          miso_o   <= tx_word[DATA_W-1];
          tx_shift <= {tx_word[DATA_W-2:0], 1'b0};
        end
      end else if (shift) begin
        miso_o   <= tx_shift[DATA_W-1];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end else if (state_next == IDLE) begin
        miso_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, driven by a
// bit-banged master at 100 MHz clk / 1 MHz SCLK.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 50;
  localparam logic [7:0] IDLE_WORD = 8'hE7;

  logic       clk, rst, mosi;
  logic [3:0] sclk, cs, miso, oe, tx_valid, tx_ready, rx_valid, rx_ready, ovr, unr;
  logic [7:0] tx_data;
  logic [7:0] rx_data [4];

  int checks = 0;
  int errors = 0;
  int unr_cnt [4] = '{0, 0, 0, 0};
  int ovr_cnt [4] = '{0, 0, 0, 0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .DATA_W (8),
      .CPOL   ((g >= 2) ? 1'b1 : 1'b0),
      .CPHA   ((g % 2 == 1) ? 1'b1 : 1'b0),
      .TX_IDLE(IDLE_WORD)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .sclk_i       (sclk[g]),
      .cs_i         (cs[g]),
      .mosi_i       (mosi),
      .miso_o       (miso[g]),
      .miso_oe_o    (oe[g]),
      .tx_data_i    (tx_data),
      .tx_valid_i   (tx_valid[g]),
      .tx_ready_o   (tx_ready[g]),
      .rx_data_o    (rx_data[g]),
      .rx_valid_o   (rx_valid[g]),
      .rx_ready_i   (rx_ready[g]),
      .rx_overrun_o (ovr[g]),
      .tx_underrun_o(unr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles each pulse output is high; a proper pulse adds exactly one.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (unr[k]) unr_cnt[k] <= unr_cnt[k] + 1;
      if (ovr[k]) ovr_cnt[k] <= ovr_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push(input int m, input logic [7:0] d);
    tx_data     = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic consume(input int m);
    rx_ready[m] = 1'b1;
    @(negedge clk);
    rx_ready[m] = 1'b0;
    check("rx_valid_clear", 32'(rx_valid[m]), 32'd0);
  endtask

  // Bit-banged master: sends the top nbits of mo, returns what it sampled on MISO.
  task automatic xfer(input int m, input logic [7:0] mo, input int nbits, input bit lat,
                      output logic [7:0] mi);
    bit cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi   = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi    = mo[i];
        half();
        sclk[m] = ~cpol;
        mi[i]   = miso[m];
        if (lat && i == 0) begin
          repeat (2) @(negedge clk);
          check("rx_lat_2clk", 32'(rx_valid[m]), 32'd0);
          @(negedge clk);
          check("rx_lat_3clk", 32'(rx_valid[m]), 32'd1);
          repeat (HALF - 3) @(negedge clk);
        end else begin
          half();
        end
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi    = mo[i];
        half();
        sclk[m] = cpol;
        mi[i]   = miso[m];
        half();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},  32'(rx_data[0]),  32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid[0]), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready[0]), 32'd1);
    check({tag, "_miso"},     32'(miso[0]),     32'd0);
    check({tag, "_miso_oe"},  32'(oe[0]),       32'd0);
    check({tag, "_overrun"},  32'(ovr[0]),      32'd0);
    check({tag, "_underrun"}, 32'(unr[0]),      32'd0);
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int base;

    rst      = 1'b1;
    cs       = 4'b1111;
    sclk     = 4'b1100;
    mosi     = 1'b0;
    tx_data  = '0;
    tx_valid = '0;
    rx_ready = '0;
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single word in every mode: slave sends 0xA5, master sends 0x3C.
    for (int m = 0; m < 4; m++) begin
      check("tx_ready_idle", 32'(tx_ready[m]), 32'd1);
      push(m, 8'hA5);
      check("tx_ready_full", 32'(tx_ready[m]), 32'd0);
      cs[m] = 1'b0;
      half();
      check("miso_oe_active", 32'(oe[m]), 32'd1);
      xfer(m, 8'h3C, 8, (m == 0), mi);
      check("mode_miso_word", 32'(mi), 32'hA5);
      check("mode_rx_valid", 32'(rx_valid[m]), 32'd1);
      check("mode_rx_data", 32'(rx_data[m]), 32'h3C);
      cs[m] = 1'b1;
      repeat (10) @(negedge clk);
      check("miso_oe_idle", 32'(oe[m]), 32'd0);
      check("miso_idle", 32'(miso[m]), 32'd0);
      consume(m);
    end

    // Back-to-back words with only the first queued.
    rx_ready[0] = 1'b1;
    base = unr_cnt[0];
    push(0, 8'hA5);
    cs[0] = 1'b0;
    half();
    xfer(0, 8'h3C, 8, 1'b0, mi);
    check("b2b_tx_ready", 32'(tx_ready[0]), 32'd1);
    push(0, 8'h99);
    xfer(0, 8'h55, 8, 1'b0, mi2);
    cs[0] = 1'b1;
    repeat (10) @(negedge clk);
    rx_ready[0] = 1'b0;
    check("b2b_word1", 32'(mi), 32'hA5);
    check("b2b_word2_idle", 32'(mi2), 32'(IDLE_WORD));
    check("b2b_rx_data", 32'(rx_data[0]), 32'h55);
    check("b2b_rx_valid", 32'(rx_valid[0]), 32'd0);
    check("b2b_underrun_cnt", 32'(unr_cnt[0] - base), 32'd1);
    check("b2b_buf_drained", 32'(tx_ready[0]), 32'd1);

    // Two unread words: second overwrites the first with one overrun pulse.
    base = ovr_cnt[0];
    cs[0] = 1'b0;
    half();
    xfer(0, 8'h11, 8, 1'b0, mi);
    check("ovr_word1", 32'(rx_data[0]), 32'h11);
    xfer(0, 8'h22, 8, 1'b0, mi);
    cs[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("ovr_cnt", 32'(ovr_cnt[0] - base), 32'd1);
    check("ovr_rx_data", 32'(rx_data[0]), 32'h22);
    check("ovr_rx_valid", 32'(rx_valid[0]), 32'd1);
    consume(0);

    // CS raised after 5 bits; buffer written mid-word must survive the abort.
    cs[0] = 1'b0;
    half();
    xfer(0, 8'hF0, 5, 1'b0, mi);
    push(0, 8'hC6);
    cs[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_valid", 32'(rx_valid[0]), 32'd0);
    check("abort_buf_kept", 32'(tx_ready[0]), 32'd0);
    cs[0] = 1'b0;
    half();
    xfer(0, 8'h7E, 8, 1'b0, mi);
    check("abort_next_miso", 32'(mi), 32'hC6);
    check("abort_next_rx", 32'(rx_data[0]), 32'h7E);
    check("abort_next_valid", 32'(rx_valid[0]), 32'd1);
    cs[0] = 1'b1;
    repeat (10) @(negedge clk);
    consume(0);

    // Reset after 3 bits; CS stays low through reset and must not start a transfer.
    cs[0] = 1'b0;
    half();
    xfer(0, 8'hFF, 3, 1'b0, mi);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    xfer(0, 8'hFF, 8, 1'b0, mi);
    check("rst_no_fresh_cs", 32'(rx_valid[0]), 32'd0);
    cs[0] = 1'b1;
    repeat (10) @(negedge clk);
    push(0, 8'h5A);
    cs[0] = 1'b0;
    half();
    xfer(0, 8'h96, 8, 1'b0, mi);
    check("rst_next_miso", 32'(mi), 32'h5A);
    check("rst_next_rx", 32'(rx_data[0]), 32'h96);
    check("rst_next_valid", 32'(rx_valid[0]), 32'd1);
    cs[0] = 1'b1;
    repeat (10) @(negedge clk);
    consume(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- DATA_W, 8, word length in bits (4..32)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- TX_IDLE, all-zeros, word shifted out when no TX data is queued
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk_i, in, 1, system clock
- rst_i, in, 1, reset
- sclk_i, in, 1, SPI clock from master, asynchronous
- cs_i, in, 1, chip select from master, active-low, asynchronous
- mosi_i, in, 1, master-out data, asynchronous
- miso_o, out, 1, slave-out data
- miso_oe_o, out, 1, MISO output enable
- tx_data_i, in, DATA_W, next word to transmit
- tx_valid_i, in, 1, tx_data_i valid
- tx_ready_o, out, 1, TX buffer empty
- rx_data_o, out, DATA_W, last received word
- rx_valid_o, out, 1, rx_data_o valid
- rx_ready_i, in, 1, consumer accepts rx_data_o
- rx_overrun_o, out, 1, one-cycle pulse: unread word overwritten
- tx_underrun_o, out, 1, one-cycle pulse: TX_IDLE loaded for lack of data
REQ-003 SHALL use one clock, clk_i; reset rst_i SHALL be synchronous and active-high.

Function
REQ-004 SHALL pass sclk_i, cs_i and mosi_i through 2-FF synchronizers on clk_i; all edge detection SHALL use the synchronized values.
REQ-005 SHALL require f(clk_i) >= 8 x f(sclk_i); behaviour at slower clk_i is undefined.
REQ-006 SHALL implement states IDLE and ACTIVE.
- IDLE -> ACTIVE on synchronized cs falling edge.
- ACTIVE -> IDLE on synchronized cs rising edge.
REQ-007 SHALL define the leading edge as an SCLK transition away from CPOL and the trailing edge as the return to CPOL.
- Sample edge = leading when CPHA=0, trailing when CPHA=1.
- Shift edge = the other edge.
REQ-008 SHALL transfer data MSB first on both MOSI and MISO.
REQ-009 SHALL load the TX shift register at each word boundary: on the IDLE->ACTIVE transition, and on the cycle a word completes while CS remains low.
- Source = TX buffer if full, else TX_IDLE.
- Loading TX_IDLE SHALL pulse tx_underrun_o for one cycle.
REQ-010 MISO bit timing:
- CPHA=0: SHALL drive the MSB on miso_o in the load cycle and advance one bit on each shift edge.
- CPHA=1: SHALL advance on each shift edge, the first leading edge presenting the MSB.
REQ-011 miso_oe_o SHALL equal the inverse of synchronized cs_i. miso_o SHALL be 0 whenever miso_oe_o is 0.
REQ-012 SHALL count sample edges with a bit counter that wraps DATA_W-1 -> 0. On the DATA_W-th sample, rx_data_o SHALL update with the assembled word one clk_i cycle after the synchronized edge is detected.
REQ-013 rx_valid_o SHALL set on word completion and clear on the cycle rx_valid_o && rx_ready_i.
- If a word completes while rx_valid_o=1 and rx_ready_i=0, rx_data_o SHALL be overwritten, rx_valid_o SHALL stay 1, and rx_overrun_o SHALL pulse.
- If completion coincides with a handshake, rx_valid_o SHALL stay 1 and no overrun SHALL be flagged.
REQ-014 The TX buffer SHALL be one word deep.
- tx_ready_o = buffer empty.
- tx_valid_i && tx_ready_o writes the buffer.
- A write and a load in the same cycle SHALL load the old content, and the buffer SHALL become full with the new word.
REQ-015 CS rising mid-word SHALL abort the transfer:
- bit counter cleared, partial RX word discarded, no rx_valid_o.
- The word already in the TX shift register is discarded; the TX buffer is untouched.
REQ-016 SHALL ignore SCLK edges in IDLE.

Reset
REQ-017 While rst_i=1, the block SHALL set:
- state IDLE, bit counter 0, TX buffer empty, synchronizers to CPOL/1/0.
- rx_data_o=0, rx_valid_o=0, tx_ready_o=1, miso_o=0, miso_oe_o=0, rx_overrun_o=0, tx_underrun_o=0.
REQ-018 Reset asserted mid-transfer SHALL abort immediately. The block SHALL need a fresh CS falling edge to start a new transfer.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Mode 0, DATA_W=8, clk 100 MHz, SCLK 1 MHz; TX buffer 0xA5, master sends 0x3C -> master reads 0xA5; rx_data_o=0x3C; rx_valid_o rises 3 clk after 8th raw rising SCLK.
- Modes 1, 2, 3 each with the same data -> identical results.
- Two words back-to-back, CS held low; only first word queued -> second MISO word = TX_IDLE; tx_underrun_o pulses once.
- rx_ready_i=0 across two words 0x11, 0x22 -> rx_overrun_o pulses once; rx_data_o=0x22.
- CS raised after 5 bits -> no rx_valid_o; next full word 0x7E received correctly.
- rst_i asserted after 3 bits -> all outputs at reset values the next cycle; the following transfer is correct.
